mat_fill: RTL and testbench
===========================

MAT_FILL -- requirements
Module: mat_fill

Interface
REQ-001 Parameter ROWS, default 1: output matrix row count, legal range >= 1.
REQ-002 Parameter COLS, default 1: output matrix column count, legal range >= 1.
REQ-003 g  interface (fixedp)  --  fixed-point parameters and common ports; element width is g.WIDTH.
REQ-004 g.clk  input  1  single clock; all state updates on its rising edge.
REQ-005 g.reset  input  1  reset, asynchronous, active-high.
REQ-006 a  input  g.WIDTH  fill value; sampled only at input handshake.
REQ-007 mode  input  2  fill pattern, sampled with a: 0 = all, 1 = diagonal, 2 = lower triangle, 3 = upper triangle.
REQ-008 in_valid  input  1  request carrying a and mode.
REQ-009 in_ready  output  1  block can accept a request.
REQ-010 f  output  [ROWS:1][COLS:1][g.WIDTH]  registered result matrix; row 1 / col 1 are the lowest index.
REQ-011 out_valid  output  1  f is complete and stable.
REQ-012 out_ready  input  1  consumer has taken f.

Function
REQ-013 FSM states SHALL be IDLE, FILL and HOLD.
REQ-014 in_ready SHALL be 1 only in IDLE, and is a combinational decode of the state.
REQ-015 Accept: on an edge in IDLE with in_valid=1, the block SHALL latch a and mode, set row counter r=1 and enter FILL.
REQ-016 In FILL, each edge SHALL write every column c of row r of f: element = latched a if the pattern selects (r,c), else all-zero; then r increments.
REQ-017 Pattern select: mode0 always; mode1 r==c; mode2 c<=r; mode3 c>=r.
REQ-018 Non-square shapes: mode1 SHALL place a only where r==c exists (min(ROWS,COLS) elements); mode2/3 SHALL use the same comparisons with no clipping.
REQ-019 The edge that writes row ROWS SHALL also enter HOLD and set out_valid=1; latency is exactly ROWS edges from accept to out_valid.
REQ-020 ROWS=1: a single FILL edge, then HOLD.
REQ-021 During FILL, rows not yet written SHALL keep their previous contents; f is valid only while out_valid=1.
REQ-022 In HOLD, f SHALL be stable, and out_valid SHALL stay 1 until an edge with out_ready=1.
REQ-023 That edge SHALL clear out_valid and enter IDLE; a new request can be accepted no earlier than the following edge.
REQ-024 in_valid SHALL be ignored in FILL and HOLD; a, mode and out_ready SHALL be ignored outside their sampling points.
REQ-025 The row counter SHALL be $clog2(ROWS+1) bits wide; no element arithmetic is performed, values are copied bit-exact.

Reset
REQ-026 Asserting g.reset at any time, including mid-FILL or in HOLD, SHALL immediately force state IDLE, f all-zero, out_valid=0, r=1 and latched a/mode to 0.
REQ-027 After reset release, in_ready SHALL be 1 and the first request SHALL behave per REQ-015 on the next edge.

Configuration
REQ-028 Macro MAT_FILL_TRI_EN: when defined, modes 2 and 3 SHALL behave per REQ-017.
REQ-029 When MAT_FILL_TRI_EN is undefined, modes 2 and 3 SHALL behave as mode 0, and no triangle compare logic is built.

Verification
REQ-030 ROWS=3, COLS=3, WIDTH=16, a=0x1234, mode0 -> out_valid exactly 3 edges after accept; all 9 elements 0x1234.
REQ-031 ROWS=2, COLS=4, mode1, a=0x00FF -> only f[1][1] and f[2][2] = 0x00FF; the other 6 elements are zero.
REQ-032 ROWS=3, COLS=3, mode2 then mode3, a=0x0007, with MAT_FILL_TRI_EN defined -> lower then upper triangle of 6 elements = 7; with the macro undefined, both give all 9 = 7.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 and a changing -> f and out_valid stable, in_ready=0, no new request accepted; out_ready=1 -> IDLE next edge.
REQ-034 Assert g.reset mid-FILL (after row 1 written) -> f all-zero and out_valid=0 immediately; a new request after release completes normally.
REQ-035 ROWS=1, COLS=1, back-to-back requests with out_ready tied to 1 -> out_valid 1 edge after each accept; accepts spaced 3 edges apart.

Source files
------------

// File: rtl/mat_fill.sv
// mat_fill: fills a ROWS x COLS matrix one row per clock with value a in a selectable pattern.
// Define MAT_FILL_TRI_EN to build the lower/upper triangle modes (2/3); otherwise they fill like mode 0.
module mat_fill #(
  parameter int ROWS  = 1,
  parameter int COLS  = 1,
  parameter int WIDTH = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    a,
  input  logic [1:0]                          mode,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [ROWS:1][COLS:1][WIDTH-1:0]    f,
  output logic                                out_valid,
  input  logic                                out_ready
);
  localparam int RW = $clog2(ROWS + 1);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  state_t                             state_q, state_d;
  logic [WIDTH-1:0]                   a_q, a_d;
  logic [1:0]                         mode_q, mode_d;
  logic [RW-1:0]                      r_q, r_d;
  logic [ROWS:1][COLS:1][WIDTH-1:0]   f_q, f_d;
  logic                               out_valid_q, out_valid_d;
  function automatic logic sel_f(input int r, input int c, input logic [1:0] m);
`ifdef MAT_FILL_TRI_EN
    return m == 2'd0 ? 1'b1 : m == 2'd1 ? (r == c) : m == 2'd2 ? (c <= r) : (c >= r);
`else
    return m == 2'd1 ? (r == c) : 1'b1;
`endif
  endfunction
  assign in_ready  = state_q == IDLE;
  assign f         = f_q;
  assign out_valid = out_valid_q;
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    mode_d      = mode_q;
    r_d         = r_q;
    f_d         = f_q;
    out_valid_d = out_valid_q;
    if (state_q == IDLE && in_valid) begin
      a_d     = a;
      mode_d  = mode;
      r_d     = RW'(1);
      state_d = FILL;
    end
    if (state_q == FILL) begin
      for (int c = 1; c <= COLS; c++)
        f_d[r_q][c] = sel_f(int'(r_q), c, mode_q) ? a_q : '0;
      r_d = r_q + RW'(1);
      if (int'(r_q) == ROWS) begin
        state_d     = HOLD;
        out_valid_d = 1'b1;
      end
    end
    if (state_q == HOLD && out_ready) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      mode_q      <= '0;
      r_q         <= RW'(1);
      f_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      mode_q      <= mode_d;
      r_q         <= r_d;
      f_q         <= f_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule

// File: tb/tb_mat_fill.sv
// tb_mat_fill: directed checks of mat_fill on 3x3, 2x4 and 1x1 instances.
module tb_mat_fill;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [1:0] mode = '0;
  logic iv33 = 1'b0, iv24 = 1'b0, iv11 = 1'b0;
  logic ir33, ir24, ir11, ov33, ov24, ov11;
  logic [3:1][3:1][15:0] f33;
  logic [2:1][4:1][15:0] f24;
  logic [1:1][1:1][15:0] f11;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mat_fill #(.ROWS(3), .COLS(3), .WIDTH(16)) u33 (.clk(clk), .reset(reset), .a(a), .mode(mode),
    .in_valid(iv33), .in_ready(ir33), .f(f33), .out_valid(ov33), .out_ready(out_ready));
  mat_fill #(.ROWS(2), .COLS(4), .WIDTH(16)) u24 (.clk(clk), .reset(reset), .a(a), .mode(mode),
    .in_valid(iv24), .in_ready(ir24), .f(f24), .out_valid(ov24), .out_ready(out_ready));
  mat_fill #(.ROWS(1), .COLS(1), .WIDTH(16)) u11 (.clk(clk), .reset(reset), .a(a), .mode(mode),
    .in_valid(iv11), .in_ready(ir11), .f(f11), .out_valid(ov11), .out_ready(out_ready));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (f33 !== '0 || f24 !== '0 || f11 !== '0) begin
      failures++;
      $display("FAIL reset_f f33=%h f24=%h f11=%h want 0", f33, f24, f11);
    end
    checks++;
    if ({ov33, ov24, ov11} !== 3'b000 || {ir33, ir24, ir11} !== 3'b111) begin
      failures++;
      $display("FAIL reset_hs ov=%b ir=%b want ov=000 ir=111", {ov33, ov24, ov11}, {ir33, ir24, ir11});
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic fill33(input logic [15:0] av, input logic [1:0] md, input logic [143:0] exp, input string nm);
    logic [143:0] prev;
    prev = f33;
    a = av; mode = md; iv33 = 1'b1;
    tick();
    iv33 = 1'b0; a = ~av; mode = ~md;
    checks++;
    if (ir33 !== 1'b0 || ov33 !== 1'b0) begin
      failures++;
      $display("FAIL %s_accept ir=%b ov=%b want 0 0", nm, ir33, ov33);
    end
    tick();
    checks++;
    if (f33[1] !== exp[47:0] || f33[3:2] !== prev[143:48] || ov33 !== 1'b0) begin
      failures++;
      $display("FAIL %s_row1 f=%h ov=%b want row1=%h upper=%h ov=0", nm, f33, ov33, exp[47:0], prev[143:48]);
    end
    tick();
    checks++;
    if (ov33 !== 1'b0) begin
      failures++;
      $display("FAIL %s_row2 ov=%b want 0", nm, ov33);
    end
    tick();
    checks++;
    if (ov33 !== 1'b1 || f33 !== exp) begin
      failures++;
      $display("FAIL %s_done ov=%b f=%h want ov=1 f=%h", nm, ov33, f33, exp);
    end
  endtask

  task automatic pop33(input string nm);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (ov33 !== 1'b0 || ir33 !== 1'b1) begin
      failures++;
      $display("FAIL %s_pop ov=%b ir=%b want 0 1", nm, ov33, ir33);
    end
  endtask

  task automatic test_fill_all();
    fill33(16'h1234, 2'd0, {9{16'h1234}}, "all");
    pop33("all");
  endtask

  task automatic test_triangles();
`ifdef MAT_FILL_TRI_EN
    fill33(16'h0007, 2'd2, {16'h7, 16'h7, 16'h7, 16'h0, 16'h7, 16'h7, 16'h0, 16'h0, 16'h7}, "lower");
    pop33("lower");
    fill33(16'h0007, 2'd3, {16'h7, 16'h0, 16'h0, 16'h7, 16'h7, 16'h0, 16'h7, 16'h7, 16'h7}, "upper");
    pop33("upper");
`else
    fill33(16'h0007, 2'd2, {9{16'h0007}}, "lower");
    pop33("lower");
    fill33(16'h0007, 2'd3, {9{16'h0007}}, "upper");
    pop33("upper");
`endif
    fill33(16'h0009, 2'd1, {16'h9, 16'h0, 16'h0, 16'h0, 16'h9, 16'h0, 16'h0, 16'h0, 16'h9}, "diag33");
    pop33("diag33");
  endtask

  task automatic test_diag_rect();
    logic [127:0] exp;
    exp = {16'h0, 16'h0, 16'h00FF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h00FF};
    a = 16'h00FF; mode = 2'd1; iv24 = 1'b1;
    tick();
    iv24 = 1'b0; a = 16'hFFFF; mode = 2'd0;
    tick();
    checks++;
    if (ov24 !== 1'b0) begin
      failures++;
      $display("FAIL diag24_row1 ov=%b want 0", ov24);
    end
    tick();
    checks++;
    if (ov24 !== 1'b1 || f24 !== exp) begin
      failures++;
      $display("FAIL diag24_done ov=%b f=%h want ov=1 f=%h", ov24, f24, exp);
    end
    checks++;
    if (f24[1][1] !== 16'h00FF || f24[2][2] !== 16'h00FF) begin
      failures++;
      $display("FAIL diag24_elem f11=%h f22=%h want 00ff 00ff", f24[1][1], f24[2][2]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (ov24 !== 1'b0 || ir24 !== 1'b1) begin
      failures++;
      $display("FAIL diag24_pop ov=%b ir=%b want 0 1", ov24, ir24);
    end
  endtask

  task automatic test_backpressure();
    fill33(16'h5555, 2'd0, {9{16'h5555}}, "bp");
    iv33 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 16'h1111 * 16'(i + 1);
      mode = 2'(i);
      tick();
      checks++;
      if (ov33 !== 1'b1 || ir33 !== 1'b0 || f33 !== {9{16'h5555}}) begin
        failures++;
        $display("FAIL bp_hold%0d ov=%b ir=%b f=%h want ov=1 ir=0 f=5555..", i, ov33, ir33, f33);
      end
    end
    iv33 = 1'b0;
    pop33("bp");
  endtask

  task automatic test_reset_mid_fill();
    a = 16'hABCD; mode = 2'd0; iv33 = 1'b1;
    tick();
    iv33 = 1'b0;
    tick();
    checks++;
    if (f33[1] !== {3{16'hABCD}} || ov33 !== 1'b0) begin
      failures++;
      $display("FAIL midrst_row1 row1=%h ov=%b want abcdabcdabcd 0", f33[1], ov33);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (f33 !== '0 || ov33 !== 1'b0 || ir33 !== 1'b1) begin
      failures++;
      $display("FAIL midrst_clear f=%h ov=%b ir=%b want 0 0 1", f33, ov33, ir33);
    end
    #2;
    reset = 1'b0;
    fill33(16'h0042, 2'd0, {9{16'h0042}}, "after_rst");
    pop33("after_rst");
  endtask

  task automatic test_back_to_back();
    logic ov_e [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic ir_e [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1; iv11 = 1'b1; a = 16'hBEEF; mode = 2'd0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (ov11 !== ov_e[i] || ir11 !== ir_e[i]) begin
        failures++;
        $display("FAIL b2b_edge%0d ov=%b ir=%b want %b %b", i + 1, ov11, ir11, ov_e[i], ir_e[i]);
      end
      if (i == 1) begin
        checks++;
        if (f11 !== 16'hBEEF) begin
          failures++;
          $display("FAIL b2b_first f=%h want beef", f11);
        end
        a = 16'hC0DE;
      end
      if (i == 4) begin
        checks++;
        if (f11 !== 16'hC0DE) begin
          failures++;
          $display("FAIL b2b_second f=%h want c0de", f11);
        end
      end
    end
    iv11 = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_all();
    test_triangles();
    test_diag_rect();
    test_backpressure();
    test_reset_mid_fill();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
